// File: rtl/dsa_simd_pkg.sv
// Shared definitions for the SIMD pixel fetch block.
// Purpose : fetch-engine state encoding, lane-count default, Q8.8 fixed-point
//           format constants and small helpers for coordinate arithmetic.
// Ports   : none (package).
package dsa_simd_pkg;

  // Default number of output lanes per fetched group.
  localparam int SIMD_WIDTH_DEF = 4;

  // Q8.8 scale format; scaled positions carry 16 integer bits and the same fraction.
  localparam int Q_INT_BITS     = 8;
  localparam int Q_FRAC_BITS    = 8;
  localparam int Q_WIDTH        = Q_INT_BITS + Q_FRAC_BITS;
  localparam int POS_WIDTH      = 16 + Q_FRAC_BITS;

  // Each lane needs a 2x2 neighbourhood: p00, p01, p10, p11.
  localparam int READS_PER_LANE = 4;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    ISSUE,
    DRAIN,
    DONE
  } fetch_state_e;

  // Scaled source position in Q16.8; bits above the 24-bit format are dropped.
  function automatic logic [POS_WIDTH-1:0] scalePos(input logic [16:0]        pos,
                                                    input logic [Q_WIDTH-1:0] scale);
    return POS_WIDTH'({16'b0, pos} * {17'b0, scale});
  endfunction

  // Clamp a coordinate to the last valid index of a dimension.
  function automatic logic [15:0] clampCoord(input logic [16:0] coord,
                                             input logic [15:0] dim);
    logic [15:0] limit;
    limit = dim - 16'd1;
    if (coord > {1'b0, limit}) return limit;
    return coord[15:0];
  endfunction

endpackage

// File: rtl/dsa_coord_gen.sv
// Per-lane source coordinate generator.
// Purpose : for one lane, scales the destination x position into the source
//           image, clamps the 2x2 neighbourhood to the image edge and forms the
//           four linear source addresses (p00, p01, p10, p11 order).
// Ports   : current_x_i/scale_x_i    destination x of lane 0 and Q8.8 x step
//           img_width_i              source width (row pitch and x clamp)
//           img_width_out_i          destination width for the lane-valid test
//           y0_i/y1_i                clamped source rows shared by all lanes
//           frac_x_o                 x interpolation fraction
//           lane_valid_o             lane lies inside the destination row
//           addr_o                   four source addresses, index = read order
module dsa_coord_gen
  import dsa_simd_pkg::*;
#(
  parameter int LANE       = 0,
  parameter int ADDR_WIDTH = 18
) (
  input  logic [15:0]                 current_x_i,
  input  logic [15:0]                 scale_x_i,
  input  logic [15:0]                 img_width_i,
  input  logic [15:0]                 img_width_out_i,
  input  logic [15:0]                 y0_i,
  input  logic [15:0]                 y1_i,
  output logic [7:0]                  frac_x_o,
  output logic                        lane_valid_o,
  output logic [3:0][ADDR_WIDTH-1:0]  addr_o
);

  logic [16:0]          posX;
  logic [POS_WIDTH-1:0] sx;
  logic [15:0]          x0;
  logic [15:0]          x1;

  // Row-major address, wrapped to the memory address width.
  function automatic logic [ADDR_WIDTH-1:0] linAddr(input logic [15:0] y,
                                                    input logic [15:0] x,
                                                    input logic [15:0] w);
    return ADDR_WIDTH'({16'b0, y} * {16'b0, w} + {16'b0, x});
  endfunction

  assign posX         = {1'b0, current_x_i} + 17'(LANE);
  assign sx           = scalePos(posX, scale_x_i);
  assign x0           = clampCoord({1'b0, sx[POS_WIDTH-1:Q_FRAC_BITS]}, img_width_i);
  assign x1           = clampCoord({1'b0, x0} + 17'd1, img_width_i);
  assign frac_x_o     = sx[Q_FRAC_BITS-1:0];
  assign lane_valid_o = (posX < {1'b0, img_width_out_i});

  assign addr_o[0] = linAddr(y0_i, x0, img_width_i);
  assign addr_o[1] = linAddr(y0_i, x1, img_width_i);
  assign addr_o[2] = linAddr(y1_i, x0, img_width_i);
  assign addr_o[3] = linAddr(y1_i, x1, img_width_i);

endmodule

// File: rtl/dsa_pixel_fetch_simd.sv
// SIMD bilinear-neighbourhood pixel fetch engine.
// Purpose : on request, computes source coordinates for SIMD_WIDTH destination
//           pixels, reads each lane's 2x2 source neighbourhood one byte per
//           cycle and presents the packed pixels with their fractions.
// Ports   : clk/rst                  clock, synchronous active-high reset
//           fetch_req/hold           start a group (IDLE only) / freeze engine
//           current_x/current_y      destination coordinate of lane 0
//           img_width_in/height_in   source dimensions
//           img_width_out            destination width
//           scale_x/scale_y          Q8.8 source step per destination pixel
//           mem_rd_en/mem_addr       source read strobe and address
//           mem_rd_data              read data, one cycle after the strobe
//           pix_out                  per lane {p11,p10,p01,p00}, lane 0 in LSBs
//           frac_x_out/frac_y_out    per-lane x fraction, shared y fraction
//           lane_valid               lane inside the destination row
//           fetch_done/busy          completion pulse / engine not idle
module dsa_pixel_fetch_simd
  import dsa_simd_pkg::*;
#(
  parameter int IMG_WIDTH_MAX  = 512,
  parameter int IMG_HEIGHT_MAX = 512,
  parameter int SIMD_WIDTH     = SIMD_WIDTH_DEF,
  parameter int ADDR_WIDTH     = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic                     hold,
  input  logic [15:0]              current_x,
  input  logic [15:0]              current_y,
  input  logic [15:0]              img_width_in,
  input  logic [15:0]              img_height_in,
  input  logic [15:0]              img_width_out,
  input  logic [15:0]              scale_x,
  input  logic [15:0]              scale_y,
  output logic                     mem_rd_en,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic [7:0]               mem_rd_data,
  output logic [SIMD_WIDTH*32-1:0] pix_out,
  output logic [SIMD_WIDTH*8-1:0]  frac_x_out,
  output logic [7:0]               frac_y_out,
  output logic [SIMD_WIDTH-1:0]    lane_valid,
  output logic                     fetch_done,
  output logic                     busy
);

  localparam int NUM_READS = READS_PER_LANE * SIMD_WIDTH;
  localparam int CNT_W     = $clog2(NUM_READS);
  localparam logic [CNT_W-1:0] LAST_READ = CNT_W'(NUM_READS - 1);

  fetch_state_e                         state_q, state_d;
  logic [CNT_W-1:0]                     readCnt_q;
  logic                                 capPending_q;
  logic [CNT_W-1:0]                     capSlot_q;
  logic [NUM_READS-1:0][ADDR_WIDTH-1:0] addr_q;
  logic [SIMD_WIDTH*32-1:0]             pix_q;
  logic [SIMD_WIDTH*8-1:0]              fracX_q;
  logic [7:0]                           fracY_q;
  logic [SIMD_WIDTH-1:0]                laneValid_q;
  logic                                 rdEn;

  logic [15:0]                                imgWidth;
  logic [15:0]                                imgHeight;
  logic [POS_WIDTH-1:0]                       sy;
  logic [15:0]                                y0;
  logic [15:0]                                y1;
  logic [SIMD_WIDTH-1:0][3:0][ADDR_WIDTH-1:0] laneAddr;
  logic [SIMD_WIDTH-1:0][7:0]                 laneFracX;
  logic [SIMD_WIDTH-1:0]                      laneValid;

  // Dimensions beyond the build-time maximum are treated as the maximum.
  assign imgWidth  = (img_width_in  > 16'(IMG_WIDTH_MAX))  ? 16'(IMG_WIDTH_MAX)  : img_width_in;
  assign imgHeight = (img_height_in > 16'(IMG_HEIGHT_MAX)) ? 16'(IMG_HEIGHT_MAX) : img_height_in;

  // The source rows are common to every lane, so they are computed once here.
  assign sy = scalePos({1'b0, current_y}, scale_y);
  assign y0 = clampCoord({1'b0, sy[POS_WIDTH-1:Q_FRAC_BITS]}, imgHeight);
  assign y1 = clampCoord({1'b0, y0} + 17'd1, imgHeight);

  for (genvar l = 0; l < SIMD_WIDTH; l++) begin : g_lane
    dsa_coord_gen #(
      .LANE       (l),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_coord (
      .current_x_i     (current_x),
      .scale_x_i       (scale_x),
      .img_width_i     (imgWidth),
      .img_width_out_i (img_width_out),
      .y0_i            (y0),
      .y1_i            (y1),
      .frac_x_o        (laneFracX[l]),
      .lane_valid_o    (laneValid[l]),
      .addr_o          (laneAddr[l])
    );

    // Lanes outside the destination row are still read but present zeros.
    assign pix_out[l*32 +: 32]  = laneValid_q[l] ? pix_q[l*32 +: 32]  : 32'd0;
    assign frac_x_out[l*8 +: 8] = laneValid_q[l] ? fracX_q[l*8 +: 8] : 8'd0;
  end

  // Next-state logic; hold freezes every transition and suppresses reads.
  always_comb begin
    state_d = state_q;
    rdEn    = 1'b0;
    if (!hold) begin
      case (state_q)
        IDLE:    if (fetch_req) state_d = CALC;
        CALC:    state_d = ISSUE;
        ISSUE: begin
          rdEn = 1'b1;
          if (readCnt_q == LAST_READ) state_d = DRAIN;
        end
        DRAIN:   state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign mem_rd_en  = rdEn;
  assign mem_addr   = rdEn ? addr_q[readCnt_q] : '0;
  assign fetch_done = (state_q == DONE) && !hold;
  assign busy       = (state_q != IDLE);
  assign frac_y_out = fracY_q;
  assign lane_valid = laneValid_q;

  // State, read sequencing and result capture. Read slot k lands in byte k of
  // pix_q, which matches the {p11,p10,p01,p00}-per-lane output packing. The
  // capture of a read runs regardless of hold, so data is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      readCnt_q    <= '0;
      capPending_q <= 1'b0;
      capSlot_q    <= '0;
      addr_q       <= '0;
      pix_q        <= '0;
      fracX_q      <= '0;
      fracY_q      <= '0;
      laneValid_q  <= '0;
    end else begin
      state_q      <= state_d;
      capPending_q <= rdEn;
      if (rdEn) begin
        readCnt_q <= readCnt_q + CNT_W'(1);
        capSlot_q <= readCnt_q;
      end
      if (capPending_q) begin
        pix_q[capSlot_q*8 +: 8] <= mem_rd_data;
      end
      if (state_q == CALC && !hold) begin
        readCnt_q   <= '0;
        addr_q      <= laneAddr;
        fracX_q     <= laneFracX;
        fracY_q     <= sy[Q_FRAC_BITS-1:0];
        laneValid_q <= laneValid;
      end
    end
  end

endmodule
